// File: rtl/main_memory_responder.sv
// Backing memory for the data cache: one line-refill read or single-word write at a time.
// Fixed LATENCY to the first beat or commit; req_ready is low while busy and requests are not queued.
// Optional MAINMEM_CWF_EN: bursts start at the requested word and wrap within the line.
module main_memory_responder #(
    parameter int WIDTH      = 32,
    parameter int ADDR_W     = 10,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 8
) (
    input  logic                          CLK,
    input  logic                          CLR,
    input  logic                          req_valid,
    input  logic                          req_write,
    input  logic [WIDTH-1:0]              req_addr,
    input  logic [WIDTH-1:0]              req_wdata,
    output logic                          req_ready,
    output logic                          rsp_valid,
    output logic [WIDTH-1:0]              rsp_data,
    output logic [$clog2(LINE_WORDS)-1:0] rsp_word,
    output logic                          rsp_last,
    output logic                          wr_done,
    output logic                          busy
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [OFF_W-1:0]   beat_q, beat_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [OFF_W-1:0]   rsp_word_q, rsp_word_d;
    logic               rsp_last_q, rsp_last_d;
    logic               wr_done_q, wr_done_d;

    logic [WIDTH-1:0]   mem [0:(1<<ADDR_W)-1];
    logic               mem_we;
    logic [OFF_W-1:0]   nxt_beat;
    logic [OFF_W-1:0]   ord;
    logic [ADDR_W-1:0]  rd_idx;
    logic               unused_bits;

`ifdef MAINMEM_CWF_EN
    assign ord         = idx_q[OFF_W-1:0] + nxt_beat;
    assign unused_bits = ^{req_addr[WIDTH-1:ADDR_W+2], req_addr[1:0]};
`else
    assign ord         = nxt_beat;
    assign unused_bits = ^{req_addr[WIDTH-1:ADDR_W+2], req_addr[1:0], idx_q[OFF_W-1:0]};
`endif

    assign rd_idx    = {idx_q[ADDR_W-1:OFF_W], ord};
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_word  = rsp_word_q;
    assign rsp_last  = rsp_last_q;
    assign wr_done   = wr_done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        beat_d      = beat_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_word_d  = '0;
        rsp_last_d  = 1'b0;
        wr_done_d   = 1'b0;
        mem_we      = 1'b0;
        // beat about to be presented: 0 when leaving WAIT, else the one after the current
        nxt_beat    = (state_q == BURST) ? beat_q + 1'b1 : '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    idx_d   = req_addr[ADDR_W+1:2];
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (write_q) begin
                        mem_we    = 1'b1;
                        wr_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d     = BURST;
                        beat_d      = '0;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = mem[rd_idx];
                        rsp_word_d  = ord;
                        rsp_last_d  = (nxt_beat == OFF_W'(LINE_WORDS - 1));
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BURST: begin
                if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
                    state_d = IDLE;
                end else begin
                    beat_d      = nxt_beat;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = mem[rd_idx];
                    rsp_word_d  = ord;
                    rsp_last_d  = (nxt_beat == OFF_W'(LINE_WORDS - 1));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            beat_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_word_q  <= '0;
            rsp_last_q  <= 1'b0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            beat_q      <= beat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_word_q  <= rsp_word_d;
            rsp_last_q  <= rsp_last_d;
            wr_done_q   <= wr_done_d;
        end
    end

    // Storage keeps its contents across reset; mem_we is already gated by the reset FSM state.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench for main_memory_responder: stimulus queues expected beats/commits with their cycle.
module tb_main_memory_responder;
    localparam int LAT = 8;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_last, wr_done, busy;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_word;

    main_memory_responder dut (
        .CLK(CLK), .CLR(CLR), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_word(rsp_word),
        .rsp_last(rsp_last), .wr_done(wr_done), .busy(busy)
    );

    initial forever #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  word;
        logic        last;
        int          cyc;
    } beat_t;

    beat_t       exp_q[$];
    int          exp_wr[$];
    logic [31:0] mdl [0:1023];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          done = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: sole owner of the check/failure counters.
    always begin
        beat_t b;
        int    wc;
        @(posedge CLK or negedge CLR);
        #1;
        if (!CLR) begin
            checks++;
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || wr_done !== 1'b0 || busy !== 1'b0 ||
                rsp_data !== 32'h0 || rsp_word !== 2'd0 || rsp_last !== 1'b0) begin
                failures++;
                $display("FAIL reset_state: got ready=%b valid=%b wr_done=%b busy=%b data=%h word=%0d last=%b, required 1 0 0 0 0 0 0",
                         req_ready, rsp_valid, wr_done, busy, rsp_data, rsp_word, rsp_last);
            end
        end else begin
            if (rsp_valid !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat: got data=%h word=%0d at cyc %0d, required no beat", rsp_data, rsp_word, cyc);
                end else begin
                    b = exp_q.pop_front();
                    if (rsp_data !== b.data || rsp_word !== b.word || rsp_last !== b.last || cyc != b.cyc) begin
                        failures++;
                        $display("FAIL beat: got data=%h word=%0d last=%b cyc=%0d, required data=%h word=%0d last=%b cyc=%0d",
                                 rsp_data, rsp_word, rsp_last, cyc, b.data, b.word, b.last, b.cyc);
                    end
                end
            end
            if (wr_done !== 1'b0) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_wr_done: got wr_done=%b at cyc %0d, required 0", wr_done, cyc);
                end else begin
                    wc = exp_wr.pop_front();
                    if (cyc != wc || req_ready !== 1'b1) begin
                        failures++;
                        $display("FAIL wr_done: got cyc=%0d ready=%b, required cyc=%0d ready=1", cyc, req_ready, wc);
                    end
                end
            end
            if (done) begin
                checks++;
                if (exp_q.size() != 0) begin
                    failures++;
                    $display("FAIL beats_missing: got %0d pending, required 0", exp_q.size());
                end
                checks++;
                if (exp_wr.size() != 0) begin
                    failures++;
                    $display("FAIL wr_done_missing: got %0d pending, required 0", exp_wr.size());
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input int nexp, input bit commit, output int t);
        int         n;
        logic [9:0] idx;
        logic [1:0] w;
        beat_t      b;
        n = 0;
        @(negedge CLK);
        while (req_ready !== 1'b1) begin
            n++;
            if (n > 200) begin
                $display("FAIL issue_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
                $fatal(1);
            end
            @(negedge CLK);
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge CLK);
        #1;
        t = cyc;
        req_valid = 1'b0;
        idx = addr[11:2];
        if (wr) begin
            if (commit) mdl[idx] = wd;
            if (nexp > 0) exp_wr.push_back(t + LAT);
        end else begin
            for (int k = 0; k < nexp; k++) begin
`ifdef MAINMEM_CWF_EN
                w = idx[1:0] + 2'(k);
`else
                w = 2'(k);
`endif
                b.data = mdl[{idx[9:2], w}];
                b.word = w;
                b.last = (k == 3);
                b.cyc  = t + LAT + k;
                exp_q.push_back(b);
            end
        end
    endtask

    initial begin
        int          t;
        logic [31:0] lines [4];
        lines = '{32'h00, 32'h10, 32'h20, 32'h40};

        // reset held with a pending write that must not be taken
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0;
        req_wdata = 32'h0BAD_BAD0;
        repeat (3) @(negedge CLK);
        CLR       = 1'b1;
        req_valid = 1'b0;

        for (int i = 0; i < 16; i++)
            issue(1'b1, lines[i/4] + 32'(4*(i%4)), 32'h1000_0000 + 32'(i*32'h111), 1, 1'b1, t);

        // write then read back the line
        issue(1'b1, 32'h14, 32'hDEAD_BEEF, 1, 1'b1, t);
        issue(1'b0, 32'h10, 32'h0, 4, 1'b0, t);

        // critical-word request
        issue(1'b0, 32'h18, 32'h0, 4, 1'b0, t);

        // request held during WAIT must be ignored
        issue(1'b1, 32'h40, 32'h1111_1111, 1, 1'b1, t);
        @(negedge CLK);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h44;
        req_wdata = 32'h2222_2222;
        while (cyc < t + LAT - 1) @(negedge CLK);
        req_valid = 1'b0;
        issue(1'b0, 32'h40, 32'h0, 4, 1'b0, t);
        issue(1'b1, 32'h44, 32'h2222_2222, 1, 1'b1, t);
        issue(1'b0, 32'h40, 32'h0, 4, 1'b0, t);

        // reset during the WAIT of a write discards it
        issue(1'b1, 32'h20, 32'hCAFE_F00D, 0, 1'b0, t);
        repeat (3) @(negedge CLK);
        CLR = 1'b0;
        repeat (2) @(negedge CLK);
        CLR = 1'b1;
        issue(1'b0, 32'h20, 32'h0, 4, 1'b0, t);

        // reset during beat 1 of a burst
        issue(1'b0, 32'h10, 32'h0, 2, 1'b0, t);
        while (cyc < t + LAT + 1) @(negedge CLK);
        CLR = 1'b0;
        repeat (2) @(negedge CLK);
        CLR = 1'b1;
        issue(1'b0, 32'h10, 32'h0, 4, 1'b0, t);

        // high address bits alias onto word 0
        issue(1'b1, 32'h1000, 32'hA5A5_A5A5, 1, 1'b1, t);
        issue(1'b0, 32'h0, 32'h0, 4, 1'b0, t);

        repeat (20) @(negedge CLK);
        done = 1'b1;
    end
endmodule
